// File: rtl/conf_pkg.sv
// Shared types and widths for the configuration encoder.
package conf_pkg;

    localparam int unsigned CONF_W    = 8;
    localparam int unsigned POWER_W   = 4;
    localparam int unsigned PTR_W     = 3;
    localparam int unsigned CNT_W     = $clog2(CONF_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // A request is legal when power fits the word and mode flags even power as heat.
    function automatic logic is_legal(input logic [POWER_W-1:0] power, input logic mode);
        return (power <= POWER_W'(CONF_W)) && (mode == ~power[0]);
    endfunction

endpackage

// File: rtl/conf_if.sv
// Request/configuration bus between a requester and the encoder.
interface conf_if;
    import conf_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [POWER_W-1:0]   req_power;
    logic                 req_mode;
    logic [CONF_W-1:0]    chs_conf;
    logic                 conf_sdata;
    logic                 conf_sframe;
    logic                 conf_done;
    logic                 conf_err;

    modport master (
        output req_valid, req_power, req_mode,
        input  req_ready, chs_conf, conf_sdata, conf_sframe, conf_done, conf_err
    );

    modport slave (
        input  req_valid, req_power, req_mode,
        output req_ready, chs_conf, conf_sdata, conf_sframe, conf_done, conf_err
    );
endinterface

// File: rtl/conf_pattern_gen.sv
// Thermometer code of the requested power, rotated left by the rotation pointer.
module conf_pattern_gen
    import conf_pkg::*;
(
    input  logic [POWER_W-1:0] power,
    input  logic [PTR_W-1:0]   rot_ptr,
    output logic [CONF_W-1:0]  word_c
);

    logic [CONF_W-1:0]   therm;
    logic [2*CONF_W-1:0] dbl;

    // Powers at or above the word width saturate to all ones; rotation via doubled word.
    always_comb begin
        therm = '0;
        for (int i = 0; i < int'(CONF_W); i++) begin
            therm[i] = (POWER_W'(i) < power);
        end
        dbl    = {therm, therm} << rot_ptr;
        word_c = dbl[2*CONF_W-1:CONF_W];
    end

endmodule

// File: rtl/conf_encoder.sv
// Accepts power/mode requests, serialises the rotated thermometer word and
// publishes it in parallel once the frame completes.
module conf_encoder
    import conf_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    conf_if.slave  bus
);

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rot_q, rot_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CONF_W-1:0]   word_q, word_d;
    logic [CONF_W-1:0]   chs_q, chs_d;
    logic                sdata_q, sdata_d;
    logic                sframe_q, sframe_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic [CONF_W-1:0]   word_c;

    conf_pattern_gen u_pattern_gen (
        .power   (bus.req_power),
        .rot_ptr (rot_q),
        .word_c  (word_c)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rot_q    <= '0;
            cnt_q    <= '0;
            word_q   <= '0;
            chs_q    <= '0;
            sdata_q  <= 1'b0;
            sframe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            rot_q    <= rot_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            chs_q    <= chs_d;
            sdata_q  <= sdata_d;
            sframe_q <= sframe_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state and next-output logic; outputs land in registers one edge later.
    always_comb begin
        state_d  = state_q;
        rot_d    = rot_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        chs_d    = chs_q;
        sdata_d  = 1'b0;
        sframe_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (is_legal(bus.req_power, bus.req_mode)) begin
                        state_d  = SEND;
                        word_d   = word_c;
                        cnt_d    = '0;
                        sdata_d  = word_c[0];
                        sframe_d = 1'b1;
                    end else begin
                        state_d  = ERR;
                        err_d    = 1'b1;
                    end
                end
            end
            SEND: begin
                if (cnt_q == CNT_W'(CONF_W - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    chs_d   = word_q;
                    rot_d   = rot_q + PTR_W'(1);
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    sdata_d  = word_q[cnt_d];
                    sframe_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    assign bus.req_ready   = ready_q;
    assign bus.chs_conf    = chs_q;
    assign bus.conf_sdata  = sdata_q;
    assign bus.conf_sframe = sframe_q;
    assign bus.conf_done   = done_q;
    assign bus.conf_err    = err_q;

endmodule

// File: tb/tb_conf_encoder.sv
// Self-checking bench for conf_encoder with a word-level reference model.
module tb_conf_encoder;
    import conf_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conf_if bus ();

    conf_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         checks = 0;
    int         errors = 0;
    int         model_ptr = 0;
    logic [7:0] exp_chs = 8'h00;

    // Expected word: p ones at the bottom, rotated left by r.
    function automatic logic [7:0] model_word(input int p, input int r);
        int t;
        t = (p >= 8) ? 255 : ((1 << p) - 1);
        return 8'(((t << r) | (t >> (8 - r))) & 255);
    endfunction

    function automatic int popcnt(input logic [7:0] w);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(w[i]);
        return c;
    endfunction

    // Issue one request and record what the outputs did over the next 11 cycles.
    task automatic do_req(input int p, input logic m, input int gcyc,
                          output logic [7:0] sbits, output int sframe_cnt,
                          output int done_cyc, output int err_cyc,
                          output logic [7:0] chs_mid, output logic [7:0] chs_end,
                          output int stray);
        int n = 0;
        sbits = '0; sframe_cnt = 0; done_cyc = -1; err_cyc = -1; stray = 0;
        chs_mid = '0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: ready=%b after %0d cycles", bus.req_ready, n);
        end
        bus.req_valid = 1'b1;
        bus.req_power = 4'(p);
        bus.req_mode  = m;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            bus.req_valid = (j <= gcyc);
            bus.req_power = 4'($urandom);
            bus.req_mode  = 1'($urandom);
            if (bus.conf_sframe === 1'b1) begin
                sframe_cnt++;
                if (j <= 8) sbits[j-1] = bus.conf_sdata; else stray++;
            end else if (bus.conf_sdata !== 1'b0) stray++;
            if (bus.conf_done === 1'b1) begin
                if (done_cyc < 0) done_cyc = j; else stray++;
            end
            if (bus.conf_err === 1'b1) begin
                if (err_cyc < 0) err_cyc = j; else stray++;
            end
            if (j == 8) chs_mid = bus.chs_conf;
        end
        chs_end = bus.chs_conf;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.chs_conf, bus.conf_sdata, bus.conf_sframe, bus.conf_done, bus.conf_err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: chs=%h sdata=%b sframe=%b done=%b err=%b, want all 0",
                     bus.chs_conf, bus.conf_sdata, bus.conf_sframe, bus.conf_done, bus.conf_err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        end
        model_ptr = 0; exp_chs = 8'h00;
    endtask

    // Legal request: serial bits, timing, parallel word and stable chs during SEND.
    task automatic test_legal(input string name, input int p, input logic m);
        logic [7:0] sbits, chs_mid, chs_end, w;
        int sfc, dc, ec, stray;
        w = model_word(p, model_ptr);
        do_req(p, m, 7, sbits, sfc, dc, ec, chs_mid, chs_end, stray);
        checks++; if (sbits !== w) begin errors++; $display("FAIL %s serial: got %h want %h", name, sbits, w); end
        checks++; if (sfc !== 8) begin errors++; $display("FAIL %s sframe_len: got %0d want 8", name, sfc); end
        checks++; if (dc !== 9) begin errors++; $display("FAIL %s done_cycle: got %0d want 9", name, dc); end
        checks++; if (ec !== -1) begin errors++; $display("FAIL %s err_seen: got %0d want -1", name, ec); end
        checks++; if (chs_mid !== exp_chs) begin errors++; $display("FAIL %s chs_during_send: got %h want %h", name, chs_mid, exp_chs); end
        checks++; if (chs_end !== w) begin errors++; $display("FAIL %s chs_conf: got %h want %h", name, chs_end, w); end
        checks++; if (stray !== 0) begin errors++; $display("FAIL %s stray_activity: got %0d want 0", name, stray); end
        model_ptr = (model_ptr + 1) % 8;
        exp_chs   = w;
    endtask

    task automatic test_first;
        test_legal("first_p3", 3, 1'b0);
        checks++; if (exp_chs !== 8'h07) begin errors++; $display("FAIL first_word_literal: got %h want 07", bus.chs_conf); end
    endtask

    task automatic test_rotation;
        for (int i = 0; i < 8; i++) test_legal("rotate_p3", 3, 1'b0);
        checks++;
        if (bus.chs_conf !== 8'h07) begin
            errors++; $display("FAIL rotate_wrap: got %h want 07", bus.chs_conf);
        end
    endtask

    // Illegal request: one err pulse at T+1, no frame, nothing else changes.
    task automatic test_illegal_one(input string name, input int p, input logic m);
        logic [7:0] sbits, chs_mid, chs_end;
        int sfc, dc, ec, stray;
        do_req(p, m, 1, sbits, sfc, dc, ec, chs_mid, chs_end, stray);
        checks++; if (ec !== 1) begin errors++; $display("FAIL %s err_cycle: got %0d want 1", name, ec); end
        checks++; if (sfc !== 0) begin errors++; $display("FAIL %s sframe_len: got %0d want 0", name, sfc); end
        checks++; if (dc !== -1) begin errors++; $display("FAIL %s done_seen: got %0d want -1", name, dc); end
        checks++; if (chs_end !== exp_chs) begin errors++; $display("FAIL %s chs_conf: got %h want %h", name, chs_end, exp_chs); end
        checks++; if (stray !== 0) begin errors++; $display("FAIL %s stray_activity: got %0d want 0", name, stray); end
    endtask

    task automatic test_illegal;
        int p;
        test_illegal_one("illegal_p4_m0", 4, 1'b0);
        test_illegal_one("illegal_p9_m0", 9, 1'b0);
        for (int i = 0; i < 4; i++) begin
            p = $urandom_range(0, 15);
            if (p > 8) test_illegal_one("illegal_rand_range", p, 1'($urandom));
            else       test_illegal_one("illegal_rand_mode", p, (p % 2 != 0));
        end
        // rotation pointer must not have moved across the rejects
        test_legal("after_illegal_p1", 1, 1'b0);
    endtask

    task automatic test_extremes;
        test_legal("power0", 0, 1'b1);
        checks++; if (bus.chs_conf !== 8'h00) begin errors++; $display("FAIL power0_word: got %h want 00", bus.chs_conf); end
        test_legal("power8", 8, 1'b1);
        checks++; if (bus.chs_conf !== 8'hFF) begin errors++; $display("FAIL power8_word: got %h want ff", bus.chs_conf); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int bad = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        bus.req_valid = 1'b1; bus.req_power = 4'd5; bus.req_mode = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.chs_conf, bus.conf_sdata, bus.conf_sframe, bus.conf_done, bus.conf_err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_outputs: chs=%h sdata=%b sframe=%b done=%b err=%b, want all 0",
                     bus.chs_conf, bus.conf_sdata, bus.conf_sframe, bus.conf_done, bus.conf_err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b want 1", bus.req_ready); end
        for (int i = 0; i < 8; i++) begin
            if (bus.conf_done !== 1'b0 || bus.conf_sframe !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL reset_mid_aborted: %0d active cycles, want 0", bad); end
        model_ptr = 0; exp_chs = 8'h00;
        test_legal("after_reset_p3", 3, 1'b0);
    endtask

    // Random legal requests with valid held high; junk inputs while busy.
    task automatic test_back_to_back;
        int   q_p[$];
        int   cyc = 0, last_acc = -1, done_n = 0, issued = 0, p, pe;
        logic m, me;
        logic [7:0] w;
        localparam int N = 12;
        @(negedge clk);
        while (done_n < N && cyc < 400) begin
            if (bus.req_ready === 1'b1 && issued < N) begin
                p = $urandom_range(0, 8);
                m = (p % 2 == 0);
                bus.req_valid = 1'b1; bus.req_power = 4'(p); bus.req_mode = m;
                q_p.push_back(p);
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== 10) begin
                        errors++; $display("FAIL b2b_spacing: got %0d want 10", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                issued++;
            end else begin
                bus.req_power = 4'($urandom);
                bus.req_mode  = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
            if (bus.conf_done === 1'b1) begin
                bus.req_valid = 1'b0;
                if (q_p.size() == 0) begin
                    checks++; errors++; $display("FAIL b2b_unexpected_done: cycle %0d", cyc);
                end else begin
                    pe = q_p.pop_front();
                    me = (pe % 2 == 0);
                    w  = model_word(pe, model_ptr);
                    checks++;
                    if (bus.chs_conf !== w) begin errors++; $display("FAIL b2b_word: got %h want %h", bus.chs_conf, w); end
                    checks++;
                    if (popcnt(bus.chs_conf) !== pe) begin errors++; $display("FAIL b2b_popcount: got %0d want %0d", popcnt(bus.chs_conf), pe); end
                    checks++;
                    if ((popcnt(bus.chs_conf) % 2 == 0) !== me) begin errors++; $display("FAIL b2b_parity: got %b want %b", (popcnt(bus.chs_conf) % 2 == 0), me); end
                    model_ptr = (model_ptr + 1) % 8;
                    exp_chs   = w;
                    done_n++;
                    if (done_n < N) bus.req_valid = 1'b1;
                end
            end
        end
        bus.req_valid = 1'b0;
        checks++;
        if (done_n !== N) begin errors++; $display("FAIL b2b_timeout: got %0d words want %0d", done_n, N); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_power = '0;
        bus.req_mode  = 1'b0;
        test_reset();
        test_first();
        test_rotation();
        test_illegal();
        test_extremes();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conf_encoder.md
CONF_ENCODER -- requirements
Module: conf_encoder

Interface
REQ-001 SHALL have port: clk  in  1  single system clock, all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: req_valid  in  1  request present.
REQ-004 SHALL have port: req_ready  out  1  block can accept a request.
REQ-005 SHALL have port: req_power  in  4  requested power (count of ones), legal range 0..8.
REQ-006 SHALL have port: req_mode  in  1  requested mode, heat=1 / cool=0.
REQ-007 SHALL have port: chs_conf  out  8  last generated configuration word (parallel, registered).
REQ-008 SHALL have port: conf_sdata  out  1  serial configuration bit, LSB first.
REQ-009 SHALL have port: conf_sframe  out  1  high while conf_sdata carries a valid bit.
REQ-010 SHALL have port: conf_done  out  1  one-cycle pulse when a word completes.
REQ-011 SHALL have port: conf_err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-012 SHALL implement FSM states IDLE, SEND, DONE, ERR; req_ready=1 only in IDLE.
REQ-013 SHALL accept a request on the cycle T with req_valid & req_ready, latching req_power and req_mode.
REQ-014 SHALL treat a request as legal iff req_power<=8 and req_mode == ~req_power[0] (even count -> heat).
REQ-015 Illegal request: SHALL go IDLE->ERR, assert conf_err at T+1 only, return to IDLE at T+2, with chs_conf and rot_ptr unchanged.
REQ-016 Legal request: SHALL form word = thermometer of req_power ones (bits 0..power-1), rotated left by 3-bit rot_ptr.
REQ-017 SEND SHALL last exactly 8 cycles (T+1..T+8) with conf_sframe=1 and conf_sdata=word[k] on cycle T+1+k.
REQ-018 DONE (T+9) SHALL assert conf_done for one cycle and load chs_conf=word on that edge, visible from T+9.
REQ-019 rot_ptr SHALL increment by 1 modulo 8 on each DONE (7 wraps to 0); ERR SHALL not change it.
REQ-020 Power 0 SHALL yield 0x00 and power 8 SHALL yield 0xFF regardless of rot_ptr.
REQ-021 Outside SEND, conf_sframe and conf_sdata SHALL be 0.
REQ-022 req_valid/req_power/req_mode changes outside IDLE SHALL be ignored; the request in flight is not affected.
REQ-023 Back-to-back: a request held valid SHALL be accepted on the first IDLE cycle after DONE/ERR (T+10 or T+2).
REQ-024 Round-trip: popcount(chs_conf) SHALL equal accepted req_power, and its even-parity flag SHALL equal req_mode.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, rot_ptr=0, bit counter=0, chs_conf=0x00, conf_sdata=0, conf_sframe=0, conf_done=0, conf_err=0.
REQ-026 Reset mid-SEND SHALL abort the word: no conf_done, chs_conf=0x00; req_ready=1 on the first cycle after rst deasserts.

Structure
REQ-027 Shared package SHALL hold the state enum, CONF_W=8, POWER_W=4, PTR_W=3.
REQ-028 Word formation SHALL be a combinational sub-module conf_pattern_gen (power, rot_ptr -> 8-bit word); FSM, counters and registers stay in conf_encoder.

Verification
REQ-029 After reset, power=3 mode=0 -> serial 1,1,1,0,0,0,0,0; conf_done at T+9; chs_conf=0x07; rot_ptr=1.
REQ-030 Repeat power=3 mode=0 -> chs_conf=0x0E; eight consecutive such requests -> 0x07,0x0E,...,0x83, then 0x07 again (wrap).
REQ-031 power=4 mode=0 (mismatch) and power=9 mode=0 -> conf_err pulse at T+1, no sframe, chs_conf unchanged.
REQ-032 power=0 mode=1 -> chs_conf=0x00; power=8 mode=1 -> chs_conf=0xFF, conf_done pulses both.
REQ-033 rst asserted at T+4 of a power=5 request -> all outputs 0, no conf_done, next request accepted.
REQ-034 Random legal requests with req_valid held high -> accept spacing exactly 10 cycles; popcount/parity of chs_conf matches every request.
